// File: rtl/stream_packer.sv
// Narrow-to-wide valid/ready packer: gathers RATIO beats of IW bits into one OW-bit word.
// Short packets (up_last early) emit a zero-padded word with dn_keep marking the filled lanes.
module stream_packer #(
  parameter int unsigned IW    = 8,
  parameter int unsigned RATIO = 4,
  localparam int unsigned OW   = IW * RATIO,
  localparam int unsigned CW   = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_vld,
  input  logic [IW-1:0]     up_dat,
  input  logic              up_last,
  output logic              up_rdy,
  output logic              dn_vld,
  output logic [OW-1:0]     dn_dat,
  output logic [RATIO-1:0]  dn_keep,
  output logic              dn_last,
  input  logic              dn_rdy
);

  localparam logic [CW-1:0] LastLane = CW'(RATIO - 1);

  logic [OW-1:0]    acc_dat_q, acc_dat_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic             acc_last_q, acc_last_d;
  logic             acc_done_q, acc_done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             dn_vld_q, dn_vld_d;
  logic [OW-1:0]    dn_dat_q, dn_dat_d;
  logic [RATIO-1:0] dn_keep_q, dn_keep_d;
  logic             dn_last_q, dn_last_d;

  logic             out_free;
  logic             xfer;
  logic             acc;
  logic [CW-1:0]    lane;
  logic             completing;

  always_comb begin
    out_free   = ~dn_vld_q | dn_rdy;
    xfer       = acc_done_q & out_free;
    up_rdy     = ~rst & (~acc_done_q | out_free);
    acc        = up_vld & up_rdy;
    // A beat accepted alongside xfer lands in the freshly cleared accumulator.
    lane       = xfer ? '0 : cnt_q;
    completing = (lane == LastLane) | up_last;
  end

  // Accumulator next state
  always_comb begin
    acc_dat_d  = acc_dat_q;
    acc_keep_d = acc_keep_q;
    acc_last_d = acc_last_q;
    acc_done_d = acc_done_q;
    cnt_d      = cnt_q;

    if (xfer) begin
      acc_dat_d  = '0;
      acc_keep_d = '0;
      acc_last_d = 1'b0;
      acc_done_d = 1'b0;
      cnt_d      = '0;
    end

    if (acc) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (lane == CW'(i)) begin
          acc_dat_d[i*IW +: IW] = up_dat;
          acc_keep_d[i]         = 1'b1;
        end
      end
      if (completing) begin
        acc_done_d = 1'b1;
        acc_last_d = up_last;
        cnt_d      = '0;
      end else begin
        cnt_d = lane + CW'(1);
      end
    end
  end

  // Output register next state; holds steady while stalled
  always_comb begin
    dn_vld_d  = dn_vld_q;
    dn_dat_d  = dn_dat_q;
    dn_keep_d = dn_keep_q;
    dn_last_d = dn_last_q;

    if (xfer) begin
      dn_vld_d  = 1'b1;
      dn_dat_d  = acc_dat_q;
      dn_keep_d = acc_keep_q;
      dn_last_d = acc_last_q;
    end else if (dn_vld_q && dn_rdy) begin
      dn_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_dat_q  <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
      acc_done_q <= 1'b0;
      cnt_q      <= '0;
      dn_vld_q   <= 1'b0;
      dn_dat_q   <= '0;
      dn_keep_q  <= '0;
      dn_last_q  <= 1'b0;
    end else begin
      acc_dat_q  <= acc_dat_d;
      acc_keep_q <= acc_keep_d;
      acc_last_q <= acc_last_d;
      acc_done_q <= acc_done_d;
      cnt_q      <= cnt_d;
      dn_vld_q   <= dn_vld_d;
      dn_dat_q   <= dn_dat_d;
      dn_keep_q  <= dn_keep_d;
      dn_last_q  <= dn_last_d;
    end
  end

  assign dn_vld  = dn_vld_q;
  assign dn_dat  = dn_dat_q;
  assign dn_keep = dn_keep_q;
  assign dn_last = dn_last_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer: a RATIO=4 instance and a RATIO=1 instance share clock/reset.
module tb_stream_packer;

  logic        clk, rst;
  logic        up_vld, up_last, up_rdy, dn_vld, dn_last, dn_rdy;
  logic [7:0]  up_dat;
  logic [31:0] dn_dat;
  logic [3:0]  dn_keep;

  logic        up_vld1, up_last1, up_rdy1, dn_vld1, dn_last1, dn_rdy1;
  logic [7:0]  up_dat1, dn_dat1;
  logic [0:0]  dn_keep1;

  int n_cmp = 0;
  int n_err = 0;

  stream_packer #(.IW(8), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_dat(up_dat), .up_last(up_last),
    .up_rdy(up_rdy), .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_keep(dn_keep),
    .dn_last(dn_last), .dn_rdy(dn_rdy)
  );

  stream_packer #(.IW(8), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .up_vld(up_vld1), .up_dat(up_dat1), .up_last(up_last1),
    .up_rdy(up_rdy1), .dn_vld(dn_vld1), .dn_dat(dn_dat1), .dn_keep(dn_keep1),
    .dn_last(dn_last1), .dn_rdy(dn_rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    up_vld = 1'b1; up_dat = d; up_last = l;
    tick();
  endtask

  task automatic test_reset();
    n_cmp++; if (up_rdy !== 1'b0) begin n_err++; $display("FAIL rst_up_rdy got %b want 0", up_rdy); end
    n_cmp++; if (up_rdy1 !== 1'b0) begin n_err++; $display("FAIL rst_up_rdy1 got %b want 0", up_rdy1); end
    n_cmp++; if (dn_vld !== 1'b0) begin n_err++; $display("FAIL rst_dn_vld got %b want 0", dn_vld); end
    n_cmp++; if (dn_keep !== 4'h0) begin n_err++; $display("FAIL rst_keep got %h want 0", dn_keep); end
    n_cmp++; if (dn_dat !== 32'h0) begin n_err++; $display("FAIL rst_dat got %h want 0", dn_dat); end
    rst = 1'b0;
    #1;
    n_cmp++; if (up_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_up_rdy got %b want 1", up_rdy); end
    tick();
  endtask

  task automatic test_full_word();
    dn_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h11 * (i + 1)), 1'b0);
    up_vld = 1'b0;
    n_cmp++; if (dn_vld !== 1'b0) begin n_err++; $display("FAIL t1_early_vld got %b want 0", dn_vld); end
    tick();
    n_cmp++; if (dn_vld !== 1'b1) begin n_err++; $display("FAIL t1_vld got %b want 1", dn_vld); end
    n_cmp++; if (dn_dat !== 32'h44332211) begin n_err++; $display("FAIL t1_dat got %h want 44332211", dn_dat); end
    n_cmp++; if (dn_keep !== 4'hF) begin n_err++; $display("FAIL t1_keep got %h want f", dn_keep); end
    n_cmp++; if (dn_last !== 1'b0) begin n_err++; $display("FAIL t1_last got %b want 0", dn_last); end
    tick();
    n_cmp++; if (dn_vld !== 1'b0) begin n_err++; $display("FAIL t1_drain got %b want 0", dn_vld); end
  endtask

  task automatic test_short_packet();
    dn_rdy = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    up_vld = 1'b0;
    tick();
    n_cmp++; if (dn_vld !== 1'b1) begin n_err++; $display("FAIL t2_vld got %b want 1", dn_vld); end
    n_cmp++; if (dn_dat !== 32'h0000BBAA) begin n_err++; $display("FAIL t2_dat got %h want 0000bbaa", dn_dat); end
    n_cmp++; if (dn_keep !== 4'h3) begin n_err++; $display("FAIL t2_keep got %h want 3", dn_keep); end
    n_cmp++; if (dn_last !== 1'b1) begin n_err++; $display("FAIL t2_last got %b want 1", dn_last); end
    // Full word closed by up_last on the final lane
    for (int i = 0; i < 4; i++) send(8'(i + 1), (i == 3));
    up_vld = 1'b0; up_last = 1'b0;
    tick();
    n_cmp++; if (dn_dat !== 32'h04030201) begin n_err++; $display("FAIL t2_next_dat got %h want 04030201", dn_dat); end
    n_cmp++; if (dn_keep !== 4'hF) begin n_err++; $display("FAIL t2_next_keep got %h want f", dn_keep); end
    n_cmp++; if (dn_last !== 1'b1) begin n_err++; $display("FAIL t2_next_last got %b want 1", dn_last); end
    tick();
  endtask

  task automatic test_back_to_back();
    int words = 0, last_e = -1, gaps = 0, rdy_low = 0;
    logic [31:0] exp;
    dn_rdy = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (e < 32) begin up_vld = 1'b1; up_dat = 8'(e + 1); up_last = 1'b0; end
      else up_vld = 1'b0;
      #1;
      if (e < 32 && up_rdy !== 1'b1) rdy_low++;
      tick();
      if (dn_vld === 1'b1) begin
        exp = {8'(4*words + 4), 8'(4*words + 3), 8'(4*words + 2), 8'(4*words + 1)};
        n_cmp++; if (dn_dat !== exp) begin n_err++; $display("FAIL t3_dat%0d got %h want %h", words, dn_dat, exp); end
        if (words > 0 && e - last_e != 4) gaps++;
        last_e = e;
        words++;
      end
    end
    n_cmp++; if (words != 8) begin n_err++; $display("FAIL t3_words got %0d want 8", words); end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL t3_gaps got %0d want 0", gaps); end
    n_cmp++; if (rdy_low != 0) begin n_err++; $display("FAIL t3_rdy_low got %0d want 0", rdy_low); end
  endtask

  task automatic test_backpressure();
    int acc_n = 0, unstable = 0;
    dn_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      up_vld = 1'b1; up_dat = 8'(8'h41 + acc_n); up_last = 1'b0;
      #1;
      if (up_rdy === 1'b1) acc_n++;
      tick();
      if (dn_vld === 1'b1 && dn_dat !== 32'h44434241) unstable++;
    end
    n_cmp++; if (acc_n != 8) begin n_err++; $display("FAIL t4_accepted got %0d want 8", acc_n); end
    n_cmp++; if (up_rdy !== 1'b0) begin n_err++; $display("FAIL t4_stall_rdy got %b want 0", up_rdy); end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL t4_unstable got %0d want 0", unstable); end
    up_vld = 1'b0; dn_rdy = 1'b1;
    #1;
    n_cmp++; if (dn_dat !== 32'h44434241) begin n_err++; $display("FAIL t4_w0 got %h want 44434241", dn_dat); end
    tick();
    n_cmp++; if (dn_vld !== 1'b1) begin n_err++; $display("FAIL t4_w1_vld got %b want 1", dn_vld); end
    n_cmp++; if (dn_dat !== 32'h48474645) begin n_err++; $display("FAIL t4_w1 got %h want 48474645", dn_dat); end
    tick();
    n_cmp++; if (dn_vld !== 1'b0) begin n_err++; $display("FAIL t4_drained got %b want 0", dn_vld); end
  endtask

  task automatic test_reset_mid_word();
    dn_rdy = 1'b1;
    send(8'h91, 1'b0);
    send(8'h92, 1'b0);
    up_dat = 8'hEE; rst = 1'b1;
    #1;
    n_cmp++; if (up_rdy !== 1'b0) begin n_err++; $display("FAIL t5_rdy_in_rst got %b want 0", up_rdy); end
    tick();
    up_vld = 1'b0;
    n_cmp++; if (dn_vld !== 1'b0) begin n_err++; $display("FAIL t5_vld got %b want 0", dn_vld); end
    n_cmp++; if (dn_keep !== 4'h0) begin n_err++; $display("FAIL t5_keep got %h want 0", dn_keep); end
    n_cmp++; if (dn_dat !== 32'h0) begin n_err++; $display("FAIL t5_dat got %h want 0", dn_dat); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send(8'(8'hA1 + i), 1'b0);
    up_vld = 1'b0;
    tick();
    n_cmp++; if (dn_dat !== 32'hA4A3A2A1) begin n_err++; $display("FAIL t5_clean_dat got %h want a4a3a2a1", dn_dat); end
    n_cmp++; if (dn_keep !== 4'hF) begin n_err++; $display("FAIL t5_clean_keep got %h want f", dn_keep); end
    tick();
  endtask

  task automatic test_ratio1();
    int words = 0, rdy_low = 0;
    logic exp_vld;
    dn_rdy1 = 1'b1; up_last1 = 1'b0;
    for (int e = 0; e < 7; e++) begin
      up_vld1 = (e < 5); up_dat1 = 8'(8'h51 + e);
      #1;
      if (e < 5 && up_rdy1 !== 1'b1) rdy_low++;
      tick();
      exp_vld = (e >= 1 && e <= 5);
      n_cmp++; if (dn_vld1 !== exp_vld) begin n_err++; $display("FAIL t6_vld%0d got %b want %b", e, dn_vld1, exp_vld); end
      if (exp_vld) begin
        words++;
        n_cmp++; if (dn_dat1 !== 8'(8'h51 + e - 1)) begin n_err++; $display("FAIL t6_dat%0d got %h want %h", e, dn_dat1, 8'(8'h51 + e - 1)); end
        n_cmp++; if (dn_keep1 !== 1'b1) begin n_err++; $display("FAIL t6_keep%0d got %b want 1", e, dn_keep1); end
      end
    end
    n_cmp++; if (rdy_low != 0) begin n_err++; $display("FAIL t6_rdy_low got %0d want 0", rdy_low); end
  endtask

  task automatic test_ratio1_toggle();
    logic [7:0]  q[$];
    logic [15:0] pat;
    int sent = 0, got = 0;
    pat = 16'b0110_1001_1100_0101;
    for (int c = 0; c < 40; c++) begin
      up_vld1 = (sent < 6); up_dat1 = 8'(8'hC0 + sent); up_last1 = 1'b0;
      dn_rdy1 = (c >= 16) ? 1'b1 : pat[c];
      #1;
      if (up_vld1 && up_rdy1 === 1'b1) begin q.push_back(up_dat1); sent++; end
      if (dn_vld1 === 1'b1 && dn_rdy1) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL t6b_order got %h want none", dn_dat1); end
        else begin
          if (dn_dat1 !== q[0]) begin n_err++; $display("FAIL t6b_order got %h want %h", dn_dat1, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      tick();
      if (got == 6) break;
    end
    up_vld1 = 1'b0;
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL t6b_count got %0d want 6", got); end
  endtask

  initial begin
    rst = 1'b1;
    up_vld = 1'b0; up_dat = '0; up_last = 1'b0; dn_rdy = 1'b0;
    up_vld1 = 1'b0; up_dat1 = '0; up_last1 = 1'b0; dn_rdy1 = 1'b0;
    tick();
    tick();
    test_reset();
    test_full_word();
    test_short_packet();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_ratio1();
    test_ratio1_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
